exu_lsu_ctrl: RTL

//  Load/store control stage downstream of the EXU AGU, upstream of DTCM SRAM and EXU long-pipe write-back.

---
 rtl/exu_lsu_ctrl_if.sv | 56 +++++
 rtl/exu_lsu_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/exu_lsu_ctrl_if.sv
// Bundle of AGU command/response, long-pipe write-back and DTCM SRAM signals.
// Latency: none (wires only).
// Backpressure: carried by the valid/ready pairs inside the bundle.
interface exu_lsu_ctrl_if #(
    parameter int XLEN            = 32,
    parameter int DTCM_ADDR_WIDTH = 16,
    parameter int ITAG_WIDTH      = 1
);
    // AGU command
    logic                         agu_cmd_valid;
    logic                         agu_cmd_ready;
    logic [DTCM_ADDR_WIDTH-1:0]   agu_cmd_addr;
    logic                         agu_cmd_read;
    logic [1:0]                   agu_cmd_size;
    logic                         agu_cmd_usign;
    logic [ITAG_WIDTH-1:0]        agu_cmd_itag;
    logic [XLEN-1:0]              agu_cmd_wdata;
    logic [XLEN/8-1:0]            agu_cmd_wmask;
    // AGU response (stores)
    logic                         agu_rsp_valid;
    logic                         agu_rsp_ready;
    logic [XLEN-1:0]              agu_rsp_rdata;
    // Long-pipe write-back (loads)
    logic                         lsu_wbck_i_valid;
    logic                         lsu_wbck_i_ready;
    logic [XLEN-1:0]              lsu_wbck_i_data;
    logic [ITAG_WIDTH-1:0]        lsu_wbck_i_itag;
    logic                         lsu_wbck_i_err;
    // DTCM SRAM
    logic                         dtcm_cs;
    logic                         dtcm_we;
    logic [DTCM_ADDR_WIDTH-3:0]   dtcm_addr;
    logic [XLEN/8-1:0]            dtcm_wem;
    logic [XLEN-1:0]              dtcm_din;
    logic [XLEN-1:0]              dtcm_dout;

    // Environment side: issues commands, consumes responses, models the SRAM
    modport master (
        output agu_cmd_valid, agu_cmd_addr, agu_cmd_read, agu_cmd_size,
               agu_cmd_usign, agu_cmd_itag, agu_cmd_wdata, agu_cmd_wmask,
               agu_rsp_ready, lsu_wbck_i_ready, dtcm_dout,
        input  agu_cmd_ready, agu_rsp_valid, agu_rsp_rdata,
               lsu_wbck_i_valid, lsu_wbck_i_data, lsu_wbck_i_itag, lsu_wbck_i_err,
               dtcm_cs, dtcm_we, dtcm_addr, dtcm_wem, dtcm_din
    );

    // LSU side
    modport slave (
        input  agu_cmd_valid, agu_cmd_addr, agu_cmd_read, agu_cmd_size,
               agu_cmd_usign, agu_cmd_itag, agu_cmd_wdata, agu_cmd_wmask,
               agu_rsp_ready, lsu_wbck_i_ready, dtcm_dout,
        output agu_cmd_ready, agu_rsp_valid, agu_rsp_rdata,
               lsu_wbck_i_valid, lsu_wbck_i_data, lsu_wbck_i_itag, lsu_wbck_i_err,
               dtcm_cs, dtcm_we, dtcm_addr, dtcm_wem, dtcm_din
    );
endinterface

// File: rtl/exu_lsu_ctrl.sv
// Load/store control: one DTCM access per AGU command, in-order responses to wbck (loads) or agu_rsp (stores).
// Latency: 2 cycles from command accept to response valid when the consumer is not stalling.
// Backpressure: agu_cmd_ready low once queued + in-flight responses fill RSP_DEPTH; heads hold until popped.
module exu_lsu_ctrl #(
    parameter int XLEN            = 32,
    parameter int DTCM_ADDR_WIDTH = 16,
    parameter int ITAG_WIDTH      = 1,
    parameter int RSP_DEPTH       = 2
) (
    input  logic           clk,
    input  logic           rst,
    exu_lsu_ctrl_if.slave  bus
);
    localparam int LANES = XLEN / 8;
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    typedef struct packed {
        logic                  read;
        logic [XLEN-1:0]       data;
        logic [ITAG_WIDTH-1:0] itag;
        logic                  err;
    } rsp_t;

    // Byte mask is rebuilt from size/offset, so the incoming mask is ignored
    logic unused_wmask;
    assign unused_wmask = ^bus.agu_cmd_wmask;

    logic [1:0]       cmd_off;
    logic             misalign;
    logic             cmd_hsk;
    logic [CNT_W-1:0] count;
    logic             inflight;
    logic [CNT_W:0]   occupancy;

    assign cmd_off   = bus.agu_cmd_addr[1:0];
    assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};

    // Accept only while every accepted command is guaranteed a FIFO slot
    assign bus.agu_cmd_ready = !rst && (occupancy < (CNT_W+1)'(RSP_DEPTH));
    assign cmd_hsk           = bus.agu_cmd_valid && bus.agu_cmd_ready;

    // Flag accesses that must not reach the SRAM
    always_comb begin
        misalign = 1'b0;
        case (bus.agu_cmd_size)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = cmd_off[0];
            2'b10:   misalign = (cmd_off != 2'b00);
            default: misalign = 1'b1;
        endcase
    end

    // SRAM request in the accept cycle, store lanes replicated across the word
    logic [LANES-1:0] store_wem;
    logic [XLEN-1:0]  store_din;
    always_comb begin
        store_wem = '0;
        store_din = bus.agu_cmd_wdata;
        case (bus.agu_cmd_size)
            2'b00: begin
                store_wem = LANES'(1) << cmd_off;
                store_din = {LANES{bus.agu_cmd_wdata[7:0]}};
            end
            2'b01: begin
                store_wem = LANES'(3) << cmd_off;
                store_din = {(LANES/2){bus.agu_cmd_wdata[15:0]}};
            end
            2'b10: begin
                store_wem = '1;
                store_din = bus.agu_cmd_wdata;
            end
            default: store_wem = '0;
        endcase
    end

    assign bus.dtcm_cs   = cmd_hsk && !misalign;
    assign bus.dtcm_we   = bus.dtcm_cs && !bus.agu_cmd_read;
    assign bus.dtcm_addr = bus.agu_cmd_addr[DTCM_ADDR_WIDTH-1:2];
    assign bus.dtcm_wem  = bus.dtcm_we ? store_wem : '0;
    assign bus.dtcm_din  = store_din;

    // In-flight slot: command attributes needed while SRAM data returns
    logic                  if_read;
    logic [1:0]            if_size;
    logic                  if_usign;
    logic [1:0]            if_off;
    logic [ITAG_WIDTH-1:0] if_itag;
    logic                  if_err;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
            if_read  <= 1'b0;
            if_size  <= 2'b00;
            if_usign <= 1'b0;
            if_off   <= 2'b00;
            if_itag  <= '0;
            if_err   <= 1'b0;
        end else begin
            inflight <= cmd_hsk;
            if (cmd_hsk) begin
                if_read  <= bus.agu_cmd_read;
                if_size  <= bus.agu_cmd_size;
                if_usign <= bus.agu_cmd_usign;
                if_off   <= cmd_off;
                if_itag  <= bus.agu_cmd_itag;
                if_err   <= misalign;
            end
        end
    end

    // Align the addressed lane to bit 0 and extend it to XLEN
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] ld_data;
    rsp_t            push_entry;
    always_comb begin
        lane    = bus.dtcm_dout >> {if_off, 3'b000};
        ld_data = lane;
        case (if_size)
            2'b00:   ld_data = {{(XLEN-8){~if_usign & lane[7]}}, lane[7:0]};
            2'b01:   ld_data = {{(XLEN-16){~if_usign & lane[15]}}, lane[15:0]};
            default: ld_data = lane;
        endcase
        push_entry.read = if_read;
        push_entry.data = (if_read && !if_err) ? ld_data : '0;
        push_entry.itag = if_itag;
        push_entry.err  = if_err;
    end

    // Response FIFO storage; occupancy is tracked separately so data needs no reset
    rsp_t             fifo_mem [RSP_DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    rsp_t             head;
    logic             head_vld;
    logic             pop;

    assign head     = fifo_mem[rptr];
    assign head_vld = (count != '0);
    assign pop      = head_vld && (head.read ? bus.lsu_wbck_i_ready : bus.agu_rsp_ready);

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Write the formatted in-flight entry at the end of its SRAM return cycle
    always_ff @(posedge clk) begin
        if (inflight) begin
            fifo_mem[wptr] <= push_entry;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop may coincide
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (inflight) wptr <= next_ptr(wptr);
            if (pop)      rptr <= next_ptr(rptr);
            case ({inflight, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign bus.lsu_wbck_i_valid = head_vld && head.read;
    assign bus.lsu_wbck_i_data  = head.data;
    assign bus.lsu_wbck_i_itag  = head.itag;
    assign bus.lsu_wbck_i_err   = head.err;
    assign bus.agu_rsp_valid    = head_vld && !head.read;
    assign bus.agu_rsp_rdata    = '0;
endmodule
